// File: rtl/load_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : load_scoreboard
//  Purpose  : Per-register in-flight load tracker for an in-order pipeline.
//             Counts accepted loads per destination register, stalls decode
//             on load-use hazards or a saturated counter, and clears on flush.
//  Options  : LOAD_SCOREBOARD_STALL_CNT_EN adds a 32-bit stall-cycle counter
//             exposed on the stall_cycles port.
//  Revision : 1.0  initial release
// ============================================================================
module load_scoreboard #(
  parameter int NREG  = 32,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             issue_valid,
  input  logic [4:0]       issue_rs1,
  input  logic [4:0]       issue_rs2,
  input  logic [1:0]       issue_rs_used,
  input  logic             issue_is_load,
  input  logic [4:0]       issue_rd,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  input  logic             flush,
  output logic             stall,
  output logic [NREG-1:0]  pending
`ifdef LOAD_SCOREBOARD_STALL_CNT_EN
  ,
  output logic [31:0]      stall_cycles
`endif
);

  // One-hot decodes of the register indices; bit 0 (x0) is always zero so
  // x0 can neither cause a hazard nor ever move its counter.
  logic [NREG-1:0] w_rs1_dec;
  logic [NREG-1:0] w_rs2_dec;
  logic [NREG-1:0] w_rd_dec;
  logic [NREG-1:0] w_wb_dec;

  // Per-register counter status.
  logic [NREG-1:0] w_nz;
  logic [NREG-1:0] w_sat;

  // Per-register increment / writeback requests for this edge.
  logic [NREG-1:0] w_inc_vec;
  logic [NREG-1:0] w_dec_vec;

  logic w_rs1_hazard;
  logic w_rs2_hazard;
  logic w_rd_full;
  logic w_stall;
  logic w_accept;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      logic [CNT_W-1:0] r_cnt;

      assign w_rs1_dec[gi] = (gi != 0) && (issue_rs1 == 5'(gi));
      assign w_rs2_dec[gi] = (gi != 0) && (issue_rs2 == 5'(gi));
      assign w_rd_dec[gi]  = (gi != 0) && (issue_rd  == 5'(gi));
      assign w_wb_dec[gi]  = (gi != 0) && (wb_rd     == 5'(gi));

      // Counter of outstanding loads to this register. A simultaneous
      // accepted load and writeback cancel out; a writeback at zero is
      // dropped so the counter never wraps downward.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_cnt <= '0;
        end else if (flush) begin
          r_cnt <= '0;
        end else if (w_inc_vec[gi] && !w_dec_vec[gi]) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end else if (w_dec_vec[gi] && !w_inc_vec[gi] && (r_cnt != '0)) begin
          r_cnt <= r_cnt - CNT_W'(1);
        end
      end

      assign w_nz[gi]  = |r_cnt;
      assign w_sat[gi] = &r_cnt;
    end
  endgenerate

  // Hazard detection only looks at registered counter state, so a writeback
  // arriving this cycle does not clear the stall; forwarding handles it.
  assign w_rs1_hazard = issue_rs_used[0] && |(w_rs1_dec & w_nz);
  assign w_rs2_hazard = issue_rs_used[1] && |(w_rs2_dec & w_nz);
  assign w_rd_full    = issue_is_load    && |(w_rd_dec  & w_sat);
  assign w_stall      = issue_valid && (w_rs1_hazard || w_rs2_hazard || w_rd_full);

  assign w_accept  = issue_valid && !w_stall && !flush;
  assign w_inc_vec = {NREG{w_accept && issue_is_load}} & w_rd_dec;
  assign w_dec_vec = {NREG{wb_valid}} & w_wb_dec;

  assign stall   = w_stall;
  assign pending = w_nz;

`ifdef LOAD_SCOREBOARD_STALL_CNT_EN
  logic [31:0] r_stall_cycles;

  // Free-running count of stalled cycles; only reset clears it, flush does not.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cycles <= '0;
    end else if (w_stall) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`endif

endmodule
`default_nettype wire
